// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of a 1-cycle-latency instruction memory.
// Holds the PC and drives the word address. The returning instruction word is
// captured, together with the PC that fetched it, into a small FIFO. Decode
// drains that FIFO over a valid/ready handshake. A branch redirect flushes
// everything and restarts fetch at the new PC. An out-of-range fetch parks the
// unit in HALT until a redirect or reset arrives.
//
// Parameters
//   ADDR_WIDTH   width of the word address / PC
//   INST_WIDTH   instruction width
//   QUEUE_DEPTH  FIFO entries (power of two, >= 2)
//   RESET_PC     PC loaded on reset
//
// Ports
//   clock           in   single clock, all state updates on posedge
//   reset           in   synchronous, active-high
//   inst_addr       out  word address to memory (redirect target bypasses pc)
//   inst_value      in   memory read data, valid the cycle after its address
//   validation      in   combinational in-range flag for inst_addr
//   redirect_valid  in   load redirect_pc and flush the FIFO and inflight fetch
//   redirect_pc     in   redirect target
//   out_valid       out  FIFO head holds an instruction
//   out_inst        out  head instruction (0 when empty)
//   out_pc          out  head PC (0 when empty)
//   out_ready       in   decode accepts the head this cycle
//   halted          out  fetch stopped on an out-of-range address
//
// Optional feature (macro FETCH_PERF_EN)
//   fetched_count   out  saturating count of FIFO pushes
//   stall_cycles    out  saturating count of RUN cycles without issue credit
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_WIDTH  = 5,
  parameter int INST_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [INST_WIDTH-1:0] inst_value,
  input  logic                  validation,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]           fetched_count,
  output logic [31:0]           stall_cycles,
`endif
  output logic                  halted
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [INST_WIDTH-1:0] fifo_inst_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [QUEUE_DEPTH];

  logic [CNT_W-1:0] occupancy;
  logic             has_credit;
  logic             can_issue;
  logic             issue_ok;
  logic             issue_bad;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Issue / handshake decode
  // ---------------------------------------------------------------------------
  // Credit counts both queued entries and the response still on its way back,
  // so a response always has a free slot when it lands. Registered values only:
  // a pop this cycle frees credit starting next cycle.
  assign occupancy  = count_q + CNT_W'(inflight_q);
  assign has_credit = (occupancy < DEPTH_C);

  // A redirect flushes the FIFO and the pending response, so it always has
  // credit and also leaves HALT in the same cycle.
  assign can_issue = redirect_valid || ((state_q == ST_RUN) && has_credit);
  assign issue_ok  = can_issue && validation;
  assign issue_bad = can_issue && !validation;

  assign inst_addr = reset          ? RESET_PC_A :
                     redirect_valid ? redirect_pc : pc_q;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A response belonging to the pre-redirect stream is dropped.
  assign push      = inflight_q && !redirect_valid;

  assign out_inst  = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign halted    = (state_q == ST_HALT);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (issue_bad) begin
      state_d = ST_HALT;
    end else if (redirect_valid) begin
      state_d = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (issue_ok) begin
      inflight_d    = 1'b1;
      inflight_pc_d = inst_addr;
      pc_d          = inst_addr + ADDR_WIDTH'(1);
    end else if (issue_bad) begin
      // Park on the failing address; equals the held pc unless a redirect
      // pointed straight out of range.
      pc_d = inst_addr;
    end

    if (redirect_valid) begin
      // Any pop this cycle has already been accepted by decode; the rest of
      // the queue is discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC_A;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q qualifies every
  // read, and the head outputs are masked to 0 while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= inst_value;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] fetched_count_q;
  logic [31:0] stall_cycles_q;
  logic        stall_now;

  assign stall_now = (state_q == ST_RUN) && !redirect_valid && !has_credit;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_count_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      if (push && !(&fetched_count_q)) begin
        fetched_count_q <= fetched_count_q + 32'd1;
      end
      if (stall_now && !(&stall_cycles_q)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign fetched_count = fetched_count_q;
  assign stall_cycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory returns
// 0x13 + address one cycle after the address, and flags addresses >= 100 as
// out of range. ADDR_WIDTH is widened to 7 so the end-of-memory boundary at
// 100 is reachable. Inputs change 1 time unit after posedge; outputs are
// sampled on the following negedge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW      = 7;
  localparam int IW      = 32;
  localparam int MEM_END = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] inst_addr;
  logic [IW-1:0] inst_value;
  logic          validation;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic          halted;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetched_count;
  logic [31:0]   stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .QUEUE_DEPTH(4),
    .RESET_PC   (0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inst_addr     (inst_addr),
    .inst_value    (inst_value),
    .validation    (validation),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
`ifdef FETCH_PERF_EN
    .fetched_count (fetched_count),
    .stall_cycles  (stall_cycles),
`endif
    .halted        (halted)
  );

  always #5 clock = ~clock;

  // Instruction memory: registered read, combinational range flag.
  always @(posedge clock) inst_value <= 32'h13 + 32'(inst_addr);
  assign validation = (32'(inst_addr) < MEM_END);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // ---------------- Reset values ----------------
    tick(); mid();
    check("rst_addr",   32'(inst_addr), 32'd0);
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_inst",   out_inst,       32'd0);
    check("rst_pc",     32'(out_pc),    32'd0);
    check("rst_halted", 32'(halted),    32'd0);
    tick();

    // ---------------- Streaming from reset ----------------
    tick(); reset = 1'b0; mid();               // R0: issue PC 0
    check("s_r0_addr",  32'(inst_addr), 32'd0);
    check("s_r0_valid", 32'(out_valid), 32'd0);
    tick(); mid();                             // R1
    check("s_r1_valid", 32'(out_valid), 32'd0);
    check("s_r1_addr",  32'(inst_addr), 32'd1);
    for (int i = 0; i < 8; i++) begin          // R2..R9: PC 0..7 back to back
      tick(); mid();
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_pc",    32'(out_pc),    32'(i));
      check("s_inst",  out_inst,       32'h13 + 32'(i));
    end

    // ---------------- Stall: FIFO fills to 4 ----------------
    tick(); reset = 1'b1; out_ready = 1'b0;
    tick(); reset = 1'b0; mid();               // R0
    for (int i = 0; i < 5; i++) tick();
    mid();                                     // R5
    check("st_r5_addr", 32'(inst_addr), 32'd4);
    for (int i = 0; i < 4; i++) tick();
    mid();                                     // R9
    check("st_r9_valid", 32'(out_valid), 32'd1);
    check("st_r9_pc",    32'(out_pc),    32'd0);
    check("st_r9_addr",  32'(inst_addr), 32'd4);
    tick(); out_ready = 1'b1; mid();           // R10: start draining
`ifdef FETCH_PERF_EN
    check("perf_fetched", fetched_count, 32'd4);
    check("perf_stall",   stall_cycles,  32'd6);
`endif
    check("dr_pc0",   32'(out_pc), 32'd0);
    check("dr_inst0", out_inst,    32'h13);
    for (int i = 1; i < 8; i++) begin          // PC 1..7, no gap or duplicate
      tick(); mid();
      check("dr_valid", 32'(out_valid), 32'd1);
      check("dr_pc",    32'(out_pc),    32'(i));
      check("dr_inst",  out_inst,       32'h13 + 32'(i));
    end

    // ---------------- Redirect with 3 queued + 1 inflight ----------------
    tick(); reset = 1'b1; out_ready = 1'b0;
    tick(); reset = 1'b0;                      // R0
    for (int i = 0; i < 4; i++) tick();        // R4
    redirect_valid = 1'b1; redirect_pc = 7'd20; mid();
    check("rd_r4_addr",  32'(inst_addr), 32'd20);
    check("rd_r4_valid", 32'(out_valid), 32'd1);
    check("rd_r4_pc",    32'(out_pc),    32'd0);
    tick(); redirect_valid = 1'b0; mid();      // R5
    check("rd_r5_valid", 32'(out_valid), 32'd0);
    check("rd_r5_addr",  32'(inst_addr), 32'd21);
    tick(); out_ready = 1'b1; mid();           // R6
    check("rd_r6_valid", 32'(out_valid), 32'd1);
    check("rd_r6_pc",    32'(out_pc),    32'd20);
    check("rd_r6_inst",  out_inst,       32'h27);
    tick(); mid();
    check("rd_r7_pc",    32'(out_pc),    32'd21);
    tick(); mid();
    check("rd_r8_pc",    32'(out_pc),    32'd22);

    // ---------------- Halt at end of memory ----------------
    tick(); redirect_valid = 1'b1; redirect_pc = 7'd96; mid();   // H0
    check("h0_addr", 32'(inst_addr), 32'd96);
    tick(); redirect_valid = 1'b0; mid();      // H1
    check("h1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin          // H2..H5: PC 96..99
      tick(); mid();
      check("h_valid", 32'(out_valid), 32'd1);
      check("h_pc",    32'(out_pc),    32'd96 + 32'(i));
      if (i == 2) check("h4_halted", 32'(halted), 32'd0);
      if (i == 3) begin
        check("h5_halted", 32'(halted),    32'd1);
        check("h5_addr",   32'(inst_addr), 32'd100);
      end
    end
    tick(); mid();                             // H6
    check("h6_valid", 32'(out_valid), 32'd0);
    check("h6_addr",  32'(inst_addr), 32'd100);
    tick(); tick(); mid();                     // H8
    check("h8_valid",  32'(out_valid), 32'd0);
    check("h8_halted", 32'(halted),    32'd1);
    tick(); redirect_valid = 1'b1; redirect_pc = 7'd0; mid();    // H9
    check("h9_halted", 32'(halted), 32'd1);
    tick(); redirect_valid = 1'b0; mid();      // H10
    check("h10_halted", 32'(halted),    32'd0);
    check("h10_valid",  32'(out_valid), 32'd0);
    tick(); mid();                             // H11
    check("h11_valid", 32'(out_valid), 32'd1);
    check("h11_pc",    32'(out_pc),    32'd0);
    check("h11_inst",  out_inst,       32'h13);
    tick(); mid();                             // H12
    check("h12_pc", 32'(out_pc), 32'd1);

    // ---------------- Reset mid-stream ----------------
    tick(); reset = 1'b1; mid();
    check("mr_addr_held", 32'(inst_addr), 32'd0);
    tick(); reset = 1'b0; mid();
    check("mr_valid",  32'(out_valid), 32'd0);
    check("mr_addr",   32'(inst_addr), 32'd0);
    check("mr_inst",   out_inst,       32'd0);
    check("mr_halted", 32'(halted),    32'd0);
    tick(); tick(); mid();
    check("mr_restart_valid", 32'(out_valid), 32'd1);
    check("mr_restart_pc",    32'(out_pc),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
